pwm_phase_gen: RTL and testbench

- Phase-accumulator PWM generator, directly downstream of the breathing-LED duty sequencer.
- Consumes a frequency word (`period`) and a compare threshold (`duty`) and produces the PWM waveform that drives the LED pin.
- New `period`/`duty` values are held in shadow registers and applied only at accumulator wrap, so every PWM cycle is glitch-free even while the sequencer changes duty continuously.
- Provides an enable, an output polarity option, a cycle-start pulse and the active duty for debug.

---
 rtl/pwm_phase_gen.sv | 65 ++++++
 tb/tb_pwm_phase_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_phase_gen.sv
// Phase-accumulator PWM generator. period/duty sit in shadow registers that
// reload only at accumulator wrap (or continuously while idle).
module pwm_phase_gen #(
    parameter int unsigned N       = 32,
    parameter bit          OUT_INV = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] period,
    input  logic [N-1:0] duty,
    output logic         pwm_out,
    output logic         cycle_start,
    output logic [N-1:0] duty_act
);

    logic [N-1:0] r_acc;
    logic [N-1:0] r_period_act;
    logic [N-1:0] r_duty_act;
    logic         r_raw;
    logic         r_wrap;
    logic         r_cycle_start;

    logic [N:0]   w_sum;
    logic         w_carry;
    logic         w_run;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_period_act};
    assign w_carry = w_sum[N];
    assign w_run   = en && (r_period_act != '0);

    // r_wrap delays the carry by one clk so cycle_start lines up with the
    // first registered compare of the new cycle (raw lags acc by one clk).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc         <= '0;
            r_period_act  <= '0;
            r_duty_act    <= '0;
            r_raw         <= 1'b0;
            r_wrap        <= 1'b0;
            r_cycle_start <= 1'b0;
        end else if (w_run) begin
            r_acc         <= w_sum[N-1:0];
            r_raw         <= (r_acc < r_duty_act);
            r_wrap        <= w_carry;
            r_cycle_start <= r_wrap;
            if (w_carry) begin
                r_period_act <= period;
                r_duty_act   <= duty;
            end
        end else begin
            r_acc         <= '0;
            r_period_act  <= period;
            r_duty_act    <= duty;
            r_raw         <= 1'b0;
            r_wrap        <= 1'b0;
            r_cycle_start <= 1'b0;
        end
    end

    assign pwm_out     = r_raw ^ OUT_INV;
    assign cycle_start = r_cycle_start;
    assign duty_act    = r_duty_act;

endmodule

// File: tb/tb_pwm_phase_gen.sv
// Directed bench: N=8 cycle-by-cycle vector table plus N=32 inverted-output
// runs for reset, timing and duty ratio.
module tb_pwm_phase_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=8, OUT_INV=0 instance
    logic       rst8, en8, pwm8, cs8;
    logic [7:0] per8, dut8, da8;

    pwm_phase_gen #(.N(8), .OUT_INV(1'b0)) u_dut8 (
        .clk(clk), .rst(rst8), .en(en8), .period(per8), .duty(dut8),
        .pwm_out(pwm8), .cycle_start(cs8), .duty_act(da8)
    );

    // N=32, OUT_INV=1 instance
    logic        rst32, en32, pwm32, cs32;
    logic [31:0] per32, dut32, da32;

    pwm_phase_gen #(.N(32), .OUT_INV(1'b1)) u_dut32 (
        .clk(clk), .rst(rst32), .en(en32), .period(per32), .duty(dut32),
        .pwm_out(pwm32), .cycle_start(cs32), .duty_act(da32)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] period;
        logic [7:0] duty;
        logic       pwm;
        logic       cs;
        logic [7:0] da;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic e, input logic [7:0] p,
                       input logic [7:0] d, input logic pw, input logic c,
                       input logic [7:0] da);
        vec_t v;
        v.rst = r; v.en = e; v.period = p; v.duty = d;
        v.pwm = pw; v.cs = c; v.da = da;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lows, first_low, cs_cnt, low_time, per_time, n;
        bit found;
        longint P, D, exp_low, exp_per;

        rst8 = 1'b0; en8 = 1'b1; per8 = 8'd64; dut8 = 8'd128;
        rst32 = 1'b0; en32 = 1'b0; per32 = '0; dut32 = '0;

        // rst, en, period, duty, exp pwm, exp cycle_start, exp duty_act
        add(0,1,64,128, 0,0,0);   add(0,1,64,128, 0,0,0);   add(0,1,64,128, 0,0,0);
        add(1,1,64,128, 0,0,128);
        add(1,1,64,128, 1,0,128); add(1,1,64,128, 1,0,128);
        add(1,1,64,128, 0,0,128); add(1,1,64,128, 0,0,128);
        add(1,1,64,128, 1,1,128); add(1,1,64,128, 1,0,128);
        add(1,1,64,128, 0,0,128); add(1,1,64,128, 0,0,128);
        add(1,1,64,128, 1,1,128); add(1,1,64,128, 1,0,128);
        // duty -> 192 with acc at 128
        add(1,1,64,192, 0,0,128); add(1,1,64,192, 0,0,192);
        add(1,1,64,192, 1,1,192); add(1,1,64,192, 1,0,192);
        add(1,1,64,192, 1,0,192); add(1,1,64,192, 0,0,192);
        // duty -> 0
        add(1,1,64,0,   1,1,192); add(1,1,64,0,   1,0,192);
        add(1,1,64,0,   1,0,192); add(1,1,64,0,   0,0,0);
        add(1,1,64,0,   0,1,0);   add(1,1,64,0,   0,0,0);
        add(1,1,64,0,   0,0,0);
        // duty -> 255
        add(1,1,64,255, 0,0,255); add(1,1,64,255, 1,1,255);
        add(1,1,64,255, 1,0,255); add(1,1,64,255, 1,0,255);
        add(1,1,64,255, 1,0,255); add(1,1,64,255, 1,1,255);
        // en low for 5 clk, duty followed live
        add(1,0,64,100, 0,0,100); add(1,0,64,50,  0,0,50);
        add(1,0,64,128, 0,0,128); add(1,0,64,128, 0,0,128);
        add(1,0,64,128, 0,0,128);
        add(1,1,64,128, 1,0,128); add(1,1,64,128, 1,0,128);
        add(1,1,64,128, 0,0,128); add(1,1,64,128, 0,0,128);
        add(1,1,64,128, 1,1,128);
        // period -> 0 taken at wrap, then back to 64
        add(1,1,0,128,  1,0,128); add(1,1,0,128,  0,0,128);
        add(1,1,0,128,  0,0,128); add(1,1,0,128,  0,0,128);
        add(1,1,0,128,  0,0,128); add(1,1,64,128, 0,0,128);
        add(1,1,64,128, 1,0,128); add(1,1,64,128, 1,0,128);
        add(1,1,64,128, 0,0,128); add(1,1,64,128, 0,0,128);
        add(1,1,64,128, 1,1,128); add(1,1,64,128, 1,0,128);
        add(1,1,64,128, 0,0,128);
        // en falls on the carry edge: no pulse, restart from 0
        add(1,0,64,128, 0,0,128); add(1,1,64,128, 1,0,128);
        // reset mid-cycle
        add(0,1,64,128, 0,0,0);   add(1,1,64,128, 0,0,128);
        add(1,1,64,128, 1,0,128);

        for (int i = 0; i < vq.size(); i++) begin
            rst8 = vq[i].rst; en8 = vq[i].en; per8 = vq[i].period; dut8 = vq[i].duty;
            tick();
            check($sformatf("v%0d pwm_out", i), pwm8, vq[i].pwm);
            check($sformatf("v%0d cycle_start", i), cs8, vq[i].cs);
            check($sformatf("v%0d duty_act", i), da8, vq[i].da);
        end

        // period=1, duty=255: one low clk per 256
        rst8 = 1'b0; tick();
        rst8 = 1'b1; en8 = 1'b1; per8 = 8'd1; dut8 = 8'd255; tick();
        check("p1 duty_act", da8, 255);
        lows = 0; first_low = 0; cs_cnt = 0;
        for (int k = 1; k <= 512; k++) begin
            tick();
            if (pwm8 == 1'b0) begin
                lows++;
                if (first_low == 0) first_low = k;
            end
            if (cs8) cs_cnt++;
        end
        check("p1 low count", lows, 2);
        check("p1 first low", first_low, 256);
        check("p1 cycle_start count", cs_cnt, 1);
        en8 = 1'b0;

        // N=32 inverted: reset level and mid-cycle reset
        tick();
        check("n32 reset pwm_out", pwm32, 1);
        check("n32 reset cycle_start", cs32, 0);
        rst32 = 1'b1; en32 = 1'b1; per32 = 32'd31815; dut32 = 32'h6FFF_FFFF;
        tick();
        check("n32 duty_act load", da32, 32'h6FFF_FFFF);
        repeat (100) tick();
        check("n32 active low", pwm32, 0);
        rst32 = 1'b0; tick();
        check("n32 mid reset pwm_out", pwm32, 1);
        check("n32 mid reset duty_act", da32, 0);

        // Timing and ratio, step scaled x8 to keep run length short
        P = 64'd254520; D = 64'h6FFF_FFFF;
        exp_low = (D + P - 1) / P;
        exp_per = (64'd1 << 32) / P;
        rst32 = 1'b1; per32 = P[31:0]; dut32 = D[31:0];
        tick();
        low_time = 0;
        found = 1'b0;
        for (n = 0; n < 20000; n++) begin
            tick();
            if (pwm32 == 1'b0) low_time++;
            else begin found = 1'b1; break; end
        end
        check("n32 low phase ended", found, 1);
        check("n32 low time", low_time, exp_low);

        found = 1'b0;
        for (n = 0; n < 20000; n++) begin
            tick();
            if (cs32) begin found = 1'b1; break; end
        end
        check("n32 first cycle_start", found, 1);
        per_time = 0;
        found = 1'b0;
        for (n = 0; n < 20000; n++) begin
            tick();
            per_time++;
            if (cs32) begin found = 1'b1; break; end
        end
        check("n32 second cycle_start", found, 1);
        check("n32 period in range",
              (per_time == exp_per || per_time == exp_per + 1), 1);
        check("n32 low ratio 7/16",
              ((low_time * 16 - per_time * 7) <= 16 &&
               (per_time * 7 - low_time * 16) <= 16), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
